// File: rtl/imem_loader.sv
// imem_loader
//   Receives a program image as a byte stream and writes it into the
//   instruction memory as 32-bit little-endian words. The CPU is held
//   while a session runs, and stays held if the image is rejected.
//   Image format: 16-bit word count N (low byte first), then N*4 bytes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               session open pulse (taken in IDLE/DONE/ERR only)
//   rx_data/valid/ready byte stream handshake
//   mem_we/a/d          registered instruction memory write port (word index)
//   cpu_hold            CPU stall request
//   busy                header or payload in progress
//   done                one-cycle pulse on successful completion
//   error               image too large; held until the next start
module imem_loader #(
    parameter int BASE_ADDR = 256,
    parameter int DEPTH     = 192,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_d,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    // Byte address one past the last word of the memory.
    localparam logic [31:0] END_ADDR = 32'(BASE_ADDR) + 32'(DEPTH) * 32'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_BYTE, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   count;
    logic [1:0]    byte_cnt;
    logic [23:0]   word_asm;
    logic [AW-1:0] index;

    logic        xfer;
    logic        start_ok;
    logic [15:0] hdr_n;
    logic [31:0] hdr_end;
    logic        oversize;
    logic        last_word;

    assign xfer     = rx_valid && rx_ready;
    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    // Full word count as it is completed by the high header byte.
    assign hdr_n    = {rx_data, count[7:0]};
    // Image end address against the memory end; all 16 bits of N take part.
    assign hdr_end  = 32'(BASE_ADDR) + {14'd0, hdr_n, 2'b00};
    assign oversize = hdr_end > END_ADDR;

    assign last_word = (16'(index) + 16'd1) == count;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_HDR_LO;
            S_HDR_LO:              if (xfer) state_nxt = S_HDR_HI;
            S_HDR_HI: begin
                if (xfer) begin
                    if (oversize)           state_nxt = S_ERR;
                    else if (hdr_n == 16'd0) state_nxt = S_DONE;
                    else                    state_nxt = S_BYTE;
                end
            end
            S_BYTE:   if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = last_word ? S_DONE : S_BYTE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b0;
        error    = 1'b0;
        case (state)
            S_HDR_LO, S_HDR_HI, S_BYTE: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            S_WRITE: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            S_ERR: begin
                cpu_hold = 1'b1;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: header count, word assembly and the registered write port.
    // The write is launched on the edge that takes the 4th byte, so mem_we
    // lines up with the WRITE state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            byte_cnt <= '0;
            word_asm <= '0;
            index    <= '0;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_d    <= '0;
            done     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= (state_nxt == S_DONE) && (state != S_DONE);

            if (start_ok) index <= '0;

            if (state == S_HDR_LO && xfer) count[7:0] <= rx_data;

            if (state == S_HDR_HI && xfer) begin
                count[15:8] <= rx_data;
                byte_cnt    <= '0;
            end

            if (state == S_BYTE && xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: word_asm[7:0]   <= rx_data;
                    2'd1: word_asm[15:8]  <= rx_data;
                    2'd2: word_asm[23:16] <= rx_data;
                    default: begin
                        mem_we <= 1'b1;
                        mem_a  <= index;
                        mem_d  <= {rx_data, word_asm};
                    end
                endcase
            end

            if (state == S_WRITE) index <= index + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int DEPTH = 192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_a;
    logic [31:0] mem_d;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.BASE_ADDR(256), .DEPTH(DEPTH), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img[$];
    logic [31:0] exp_d[$];
    logic [7:0]  got_a[$];
    logic [31:0] got_d[$];
    int          got_c[$];
    int          done_cnt, done_cyc, err_cyc, hdr_cyc;
    bit          err_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observer: collect writes and pulses, check per-cycle rules.
    always @(negedge clk) begin
        if (mem_we) begin
            got_a.push_back(mem_a);
            got_d.push_back(mem_d);
            got_c.push_back(cyc);
            chk("write_cycle_ready_hold", {62'd0, rx_ready, cpu_hold}, 64'd1);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_cycle_hold_busy", {62'd0, cpu_hold, busy}, 64'd0);
        end
        if (error && !err_prev) err_cyc = cyc;
        err_prev = error;
    end

    // Reference: words rebuilt straight from the byte image.
    task automatic build_model(output bit m_err, output int m_n);
        m_n = int'(img[0]) + 256 * int'(img[1]);
        m_err = m_n > DEPTH;
        exp_d.delete();
        if (!m_err)
            for (int i = 0; i < m_n; i++)
                exp_d.push_back({img[4*i+5], img[4*i+4], img[4*i+3], img[4*i+2]});
    endtask

    task automatic build_image(input int n, input int pat);
        logic [31:0] w;
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
        if (n <= DEPTH)
            for (int i = 0; i < n; i++) begin
                if (pat == 0)      w = (i == 0) ? 32'h0000_0013 : 32'h0010_0093;
                else if (pat == 1) w = 32'hC0DE_0000 + 32'(i);
                else               w = $urandom;
                for (int b = 0; b < 4; b++) img.push_back(w[8*b +: 8]);
            end
    endtask

    // Called at the "#1 after posedge" phase; returns in the same phase.
    task automatic start_session(input bit rnd);
        start    = 1'b1;
        rx_valid = rnd;
        rx_data  = 8'($urandom);
        @(posedge clk); #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("ready_after_start", {63'd0, rx_ready}, 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd, input bit inj_start);
        bit acc;
        int bound;
        if (rnd) begin
            repeat ($urandom_range(0, 3)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = inj_start;
        bound    = 0;
        forever begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) break;
            bound++;
            if (bound > 30) begin
                checks++;
                errors++;
                $display("FAIL rx_accept_timeout: byte %0h never accepted, required within 30 cycles", b);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    // exp_w / exp_e < 0 means "take it from the reference model".
    task automatic run_image(input bit rnd, input int exp_w, input int exp_e);
        bit m_err;
        int m_n;
        bit e;
        build_model(m_err, m_n);
        e = (exp_e < 0) ? m_err : exp_e[0];
        got_a.delete(); got_d.delete(); got_c.delete();
        done_cnt = 0; done_cyc = -1; err_cyc = -1; hdr_cyc = -1;
        start_session(rnd);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], rnd, rnd && ($urandom_range(0, 5) == 0));
            if (i == 1) hdr_cyc = cyc;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("n_writes", 64'(got_d.size()), (exp_w < 0) ? 64'(exp_d.size()) : 64'(exp_w));
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            chk("write_addr", 64'(got_a[i]), 64'(i));
            chk("write_data", 64'(got_d[i]), 64'(exp_d[i]));
        end
        chk("error", {63'd0, error}, {63'd0, e});
        chk("done_count", 64'(done_cnt), e ? 64'd0 : 64'd1);
        chk("hold_after", {63'd0, cpu_hold}, {63'd0, e});
        chk("busy_after", {63'd0, busy}, 64'd0);
        if (e)
            chk("error_latency", 64'(err_cyc), 64'(hdr_cyc));
        else if (m_n == 0)
            chk("done_latency_empty", 64'(done_cyc), 64'(hdr_cyc));
        else if (got_c.size() > 0)
            chk("done_latency", 64'(done_cyc), 64'(got_c[got_c.size()-1] + 1));
    endtask

    typedef struct {
        int n;
        int pat;
        bit rnd;
        int exp_writes;
        int exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{n: 2,      pat: 0, rnd: 1'b0, exp_writes: 2,   exp_err: 0};
        vecs[1] = '{n: 192,    pat: 1, rnd: 1'b0, exp_writes: 192, exp_err: 0};
        vecs[2] = '{n: 193,    pat: 2, rnd: 1'b0, exp_writes: 0,   exp_err: 1};
        vecs[3] = '{n: 0,      pat: 2, rnd: 1'b0, exp_writes: 0,   exp_err: 0};
        vecs[4] = '{n: 256,    pat: 2, rnd: 1'b0, exp_writes: 0,   exp_err: 1};
        vecs[5] = '{n: 1,      pat: 2, rnd: 1'b1, exp_writes: 1,   exp_err: 0};
        vecs[6] = '{n: 'h0140, pat: 2, rnd: 1'b1, exp_writes: 0,   exp_err: 1};
        vecs[7] = '{n: 37,     pat: 2, rnd: 1'b1, exp_writes: 37,  exp_err: 0};
        vecs[8] = '{n: 192,    pat: 2, rnd: 1'b1, exp_writes: 192, exp_err: 0};

        // Reset values
        #12;
        chk("reset_outputs", {18'd0, rx_ready, mem_we, mem_a, mem_d, cpu_hold, busy, done, error}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            build_image(vecs[v].n, vecs[v].pat);
            run_image(vecs[v].rnd, vecs[v].exp_writes, vecs[v].exp_err);
            if (v == 0) begin
                chk("basic_w0", {got_a.size() > 0 ? got_a[0] : 8'hFF,
                                 got_d.size() > 0 ? got_d[0] : 32'hFFFF_FFFF},
                    {8'd0, 32'h0000_0013});
                chk("basic_w1", {got_a.size() > 1 ? got_a[1] : 8'hFF,
                                 got_d.size() > 1 ? got_d[1] : 32'hFFFF_FFFF},
                    {8'd1, 32'h0010_0093});
            end
            if (v == 1)
                chk("full_last_addr", got_a.size() > 0 ? 64'(got_a[got_a.size()-1]) : 64'hFFFF, 64'd191);
        end

        // Randomized images against the reference model
        for (int r = 0; r < 6; r++) begin
            build_image(int'($urandom_range(0, 200)), 2);
            run_image(1'b1, -1, -1);
        end

        // Reset in the middle of a word: nothing may be written
        got_a.delete(); got_d.delete(); got_c.delete();
        start_session(1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {18'd0, rx_ready, mem_we, mem_a, mem_d, cpu_hold, busy, done, error}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_write_after_reset", 64'(got_d.size()), 64'd0);

        img.delete();
        img.push_back(8'h01); img.push_back(8'h00);
        img.push_back(8'h37); img.push_back(8'h05); img.push_back(8'h00); img.push_back(8'h80);
        run_image(1'b0, 1, 0);
        chk("fresh_load_word", {got_a.size() > 0 ? got_a[0] : 8'hFF,
                                got_d.size() > 0 ? got_d[0] : 32'hFFFF_FFFF},
            {8'd0, 32'h8000_0537});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end, required end before 2000000");
        $fatal(1);
    end

endmodule
